// File: rtl/pu_or1k_spr_timer_arbiter_if.sv
// Port bundle for the tick-timer SPR arbiter: two requesting
// masters (core, debug) and the shared SPR bus toward the timer.
`timescale 1ns/1ps
interface pu_or1k_spr_timer_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic          core_req_i;
  logic          core_we_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_dat_i;
  logic          core_ack_o;
  logic          core_err_o;
  logic [DW-1:0] core_dat_o;

  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_dat_i;
  logic          dbg_ack_o;
  logic          dbg_err_o;
  logic [DW-1:0] dbg_dat_o;

  logic          spr_access_o;
  logic          spr_we_o;
  logic [AW-1:0] spr_addr_o;
  logic [DW-1:0] spr_dat_o;
  logic          spr_bus_ack_i;
  logic [DW-1:0] spr_dat_i;

  modport slave (
    input  core_req_i, core_we_i,
    input  core_addr_i, core_dat_i,
    output core_ack_o, core_err_o,
    output core_dat_o,
    input  dbg_req_i, dbg_we_i,
    input  dbg_addr_i, dbg_dat_i,
    output dbg_ack_o, dbg_err_o,
    output dbg_dat_o,
    output spr_access_o, spr_we_o,
    output spr_addr_o, spr_dat_o,
    input  spr_bus_ack_i, spr_dat_i
  );

  modport master (
    output core_req_i, core_we_i,
    output core_addr_i, core_dat_i,
    input  core_ack_o, core_err_o,
    input  core_dat_o,
    output dbg_req_i, dbg_we_i,
    output dbg_addr_i, dbg_dat_i,
    input  dbg_ack_o, dbg_err_o,
    input  dbg_dat_o,
    input  spr_access_o, spr_we_o,
    input  spr_addr_o, spr_dat_o,
    output spr_bus_ack_i, spr_dat_i
  );
endinterface

// File: rtl/pu_or1k_spr_timer_arbiter.sv
// Round-robin arbiter of core/debug SPR ports onto the tick timer,
// with registered completion and a no-ack timeout.
`timescale 1ns/1ps
module pu_or1k_spr_timer_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  pu_or1k_spr_timer_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, GRANT, DONE
  } state_t;

  state_t        state, state_n;
  logic          lg, lg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          acc, acc_n;
  logic          we, we_n;
  logic [AW-1:0] addr, addr_n;
  logic [DW-1:0] wd, wd_n;
  logic          c_ack, c_ack_n;
  logic          c_err, c_err_n;
  logic          d_ack, d_ack_n;
  logic          d_err, d_err_n;
  logic [DW-1:0] c_dat, c_dat_n;
  logic [DW-1:0] d_dat, d_dat_n;
  logic          pick_dbg;
  logic          win_req;

  // lg is the current/last winner: 1 = debug, 0 = core
  assign pick_dbg = bus.dbg_req_i
                  & (~bus.core_req_i | ~lg);
  assign win_req  = lg ? bus.dbg_req_i
                       : bus.core_req_i;

  always_comb begin
    state_n = state;
    lg_n    = lg;
    cnt_n   = cnt;
    acc_n   = acc;
    we_n    = we;
    addr_n  = addr;
    wd_n    = wd;
    c_ack_n = 1'b0;
    c_err_n = 1'b0;
    d_ack_n = 1'b0;
    d_err_n = 1'b0;
    c_dat_n = c_dat;
    d_dat_n = d_dat;
    case (state)
      IDLE: begin
        if (bus.core_req_i | bus.dbg_req_i) begin
          state_n = GRANT;
          lg_n    = pick_dbg;
          cnt_n   = '0;
          acc_n   = 1'b1;
          if (pick_dbg) begin
            we_n   = bus.dbg_we_i;
            addr_n = bus.dbg_addr_i;
            wd_n   = bus.dbg_dat_i;
          end else begin
            we_n   = bus.core_we_i;
            addr_n = bus.core_addr_i;
            wd_n   = bus.core_dat_i;
          end
        end
      end
      GRANT: begin
        if (!win_req) begin
          state_n = IDLE;
          acc_n   = 1'b0;
        end else if (bus.spr_bus_ack_i) begin
          state_n = DONE;
          acc_n   = 1'b0;
          if (lg) begin
            d_ack_n = 1'b1;
            d_dat_n = bus.spr_dat_i;
          end else begin
            c_ack_n = 1'b1;
            c_dat_n = bus.spr_dat_i;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = DONE;
          acc_n   = 1'b0;
          cnt_n   = cnt + CW'(1);
          if (lg) begin
            d_err_n = 1'b1;
            d_dat_n = '0;
          end else begin
            c_err_n = 1'b1;
            c_dat_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lg    <= 1'b1;
      cnt   <= '0;
      acc   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wd    <= '0;
      c_ack <= 1'b0;
      c_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      c_dat <= '0;
      d_dat <= '0;
    end else begin
      state <= state_n;
      lg    <= lg_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      we    <= we_n;
      addr  <= addr_n;
      wd    <= wd_n;
      c_ack <= c_ack_n;
      c_err <= c_err_n;
      d_ack <= d_ack_n;
      d_err <= d_err_n;
      c_dat <= c_dat_n;
      d_dat <= d_dat_n;
    end
  end

  assign bus.spr_access_o = acc;
  assign bus.spr_we_o     = we;
  assign bus.spr_addr_o   = addr;
  assign bus.spr_dat_o    = wd;
  assign bus.core_ack_o   = c_ack;
  assign bus.core_err_o   = c_err;
  assign bus.core_dat_o   = c_dat;
  assign bus.dbg_ack_o    = d_ack;
  assign bus.dbg_err_o    = d_err;
  assign bus.dbg_dat_o    = d_dat;
endmodule
